uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Sits downstream of the UART receiver. Consumes its byte stream (byte plus one-cycle ready strobe) and assembles framed command packets with a checksum. Presents each good packet on a valid/ready output port and flags malformed frames. It is the bridge between the raw serial link and the register/command logic behind it.

## Interface
- `MAX_LEN`, default 8: maximum payload bytes per frame (1..15).
- `TIMEOUT_CYCLES`, default 100000: idle clock cycles allowed between bytes inside a frame.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: reset. Asynchronous assert, active-low; release is synchronous to `clk` upstream.
- `rx_data`  in  8: received byte; sampled only when `rx_strobe`=1.
- `rx_strobe`  in  1: one-cycle pulse per received byte (the receiver's `rx_ready`).
- `pkt_valid`  out  1: a complete, checksum-good packet is presented.
- `pkt_ready`  in  1: consumer accepts the packet when `pkt_valid`=1.
- `pkt_cmd`  out  8: command byte.
- `pkt_len`  out  8: payload length, 0..`MAX_LEN`.
- `pkt_data`  out  8*`MAX_LEN`: payload. Byte i is at bits [8i+7:8i]; bytes at index ≥ `pkt_len` are zero.
- `err_chk`  out  1: one-cycle pulse on checksum mismatch.
- `err_len`  out  1: one-cycle pulse when the length byte exceeds `MAX_LEN`.
- `err_timeout`  out  1: one-cycle pulse on inter-byte timeout.
- `overrun`  out  1: one-cycle pulse when a byte is dropped while a packet is held.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- Frame format: SOF (0xA5), CMD, LEN, LEN payload bytes, CHK.
- CHK = XOR of CMD, LEN and all payload bytes. SOF is excluded from CHK.
- States: IDLE, CMD, LEN, DATA, CHK, HOLD.
- IDLE:
  - strobe with 0xA5 → CMD, and the payload register is cleared to zero.
  - Any other byte is ignored silently, with no error.
- CMD: strobe → latch `pkt_cmd`, init running XOR = byte → LEN.
- LEN: on strobe:
  - byte > `MAX_LEN` → pulse `err_len`, go to IDLE.
  - byte = 0 → CHK.
  - otherwise → DATA.
  - In all cases the byte is latched and XORed.
- DATA: each strobe stores the byte at the current index, XORs it, and increments the index. After the LEN-th byte → CHK.
- CHK: on strobe:
  - byte = running XOR → HOLD.
  - mismatch → pulse `err_chk`, go to IDLE.
- HOLD: `pkt_valid`=1 and outputs are stable. When `pkt_valid`&`pkt_ready` → IDLE on the next edge.
- Bytes arriving in HOLD, including the handshake cycle, are dropped and pulse `overrun`.
- Timeout: in CMD, LEN, DATA and CHK a counter counts cycles without a strobe, and any strobe clears it. When the count reaches `TIMEOUT_CYCLES` → pulse `err_timeout`, go to IDLE. The counter is held at zero in IDLE and HOLD.
- Reset values:
  - state = IDLE.
  - `pkt_valid`, `busy` and all error pulses = 0.
  - `pkt_cmd`, `pkt_len`, `pkt_data` = 0.
  - Counter and index = 0.
- Reset mid-frame or mid-HOLD discards everything immediately (asynchronous).

## Timing
- `pkt_valid` rises on the clock edge that samples the CHK strobe, so it is visible one cycle after the strobe.
- Error pulses rise on the edge that samples the offending strobe (or the timeout terminal count) and last exactly one cycle.
- `busy` rises the cycle after the SOF strobe.
- Earliest next SOF after a handshake is the cycle after `pkt_valid` falls.
- Back-to-back strobes on consecutive cycles are supported in every state.

## Structure
- Shared package `uart_pkg`:
  - `UART_SOF` = 8'hA5.
  - The parser state enum.
- Natural sub-module `uart_byte_timeout`: a counter with clear, enable and a terminal-count pulse, parameterised by `TIMEOUT_CYCLES`.
- Everything else lives in one FSM plus datapath.

## Test plan
- Good frame: A5 10 02 11 22 21 with `pkt_ready`=1.
  - → one `pkt_valid` cycle.
  - → cmd=0x10, len=2, data[15:0]=0x2211, upper bytes 0, no errors.
- Zero-length frame: A5 55 00 55.
  - → packet with len=0, `pkt_data`=0.
  - Also feed leading garbage 00 FF before the frame → ignored with no error.
- Bad checksum: A5 10 02 11 22 20.
  - → `err_chk` pulse, no `pkt_valid`.
  - → back in IDLE; a following good frame is accepted.
- Length overflow (`MAX_LEN`=8): A5 10 09.
  - → `err_len` pulse on the third byte, `busy` drops.
- Timeout (`TIMEOUT_CYCLES`=16): send A5 10, then stall.
  - → `err_timeout` exactly 16 cycles after the last strobe.
  - → a stall of 15 cycles raises no error.
- Backpressure, overrun and reset:
  - Hold `pkt_ready`=0 for 50 cycles after a good frame while sending 3 bytes → 3 `overrun` pulses, packet fields unchanged.
  - Assert `rst_n`=0 mid-DATA → all outputs zero immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command parser: frame marker and parser states.
package uart_pkg;

    localparam logic [7:0] UART_SOF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_HOLD
    } parser_state_e;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and flags the terminal count.
module uart_byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Terminal count fires on the edge where the idle count would reach TIMEOUT_CYCLES.
    assign tc_c = en_i && !clr_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i || tc_c) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SOF/CMD/LEN/payload/CHK frames from the UART byte stream and holds good packets
// on a valid/ready port; malformed frames, timeouts and dropped bytes raise one-cycle pulses.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_strobe,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [7:0]           pkt_cmd,
    output logic [7:0]           pkt_len,
    output logic [8*MAX_LEN-1:0] pkt_data,
    output logic                 err_chk,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DW = 8 * MAX_LEN;
    localparam int unsigned IW = 4;

    parser_state_e state_q;
    logic [7:0]    cmd_q;
    logic [7:0]    len_q;
    logic [7:0]    xor_q;
    logic [DW-1:0] data_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;
    logic          busy_q;
    logic          err_chk_q;
    logic          err_len_q;
    logic          err_to_q;
    logic          ovr_q;
    logic          active_c;
    logic          tc_c;

    // Only the in-frame states run the idle counter; IDLE and HOLD keep it at zero.
    assign active_c = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_DATA) || (state_q == ST_CHK);

    uart_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (rx_strobe || !active_c),
        .en_i  (active_c),
        .tc_c  (tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            len_q     <= '0;
            xor_q     <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            ovr_q     <= 1'b0;
            if (tc_c) begin
                err_to_q <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_strobe && (rx_data == UART_SOF)) begin
                            data_q  <= '0;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (rx_strobe) begin
                            cmd_q   <= rx_data;
                            xor_q   <= rx_data;
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_strobe) begin
                            len_q <= rx_data;
                            xor_q <= xor_q ^ rx_data;
                            if (rx_data > 8'(MAX_LEN)) begin
                                err_len_q <= 1'b1;
                                busy_q    <= 1'b0;
                                state_q   <= ST_IDLE;
                            end else if (rx_data == 8'd0) begin
                                state_q <= ST_CHK;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rx_strobe) begin
                            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                                if (idx_q == IW'(i)) begin
                                    data_q[i*8 +: 8] <= rx_data;
                                end
                            end
                            xor_q <= xor_q ^ rx_data;
                            idx_q <= idx_q + IW'(1);
                            if (8'(idx_q + IW'(1)) == len_q) begin
                                state_q <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (rx_strobe) begin
                            if (rx_data == xor_q) begin
                                valid_q <= 1'b1;
                                state_q <= ST_HOLD;
                            end else begin
                                err_chk_q <= 1'b1;
                                busy_q    <= 1'b0;
                                state_q   <= ST_IDLE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // Packet fields stay frozen; any byte arriving now is lost.
                        if (rx_strobe) begin
                            ovr_q <= 1'b1;
                        end
                        if (pkt_ready) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pkt_valid   = valid_q;
    assign pkt_cmd     = cmd_q;
    assign pkt_len     = len_q;
    assign pkt_data    = data_q;
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_to_q;
    assign overrun     = ovr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (MAX_LEN=8, TIMEOUT_CYCLES=16).
module tb_uart_cmd_parser;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned TMO     = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           rx_data;
    logic                 rx_strobe;
    logic                 pkt_valid;
    logic                 pkt_ready;
    logic [7:0]           pkt_cmd;
    logic [7:0]           pkt_len;
    logic [8*MAX_LEN-1:0] pkt_data;
    logic                 err_chk;
    logic                 err_len;
    logic                 err_timeout;
    logic                 overrun;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_chk = 0;
    int n_len = 0;
    int n_to = 0;
    int n_ovr = 0;
    int b_valid, b_chk, b_len, b_to, b_ovr;

    uart_cmd_parser #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_cmd     (pkt_cmd),
        .pkt_len     (pkt_len),
        .pkt_data    (pkt_data),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse/level occupancy counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_valid)   n_valid++;
            if (err_chk)     n_chk++;
            if (err_len)     n_len++;
            if (err_timeout) n_to++;
            if (overrun)     n_ovr++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one sampling edge; return #1 after that edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_strobe = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_strobe = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_chk   = n_chk;
        b_len   = n_len;
        b_to    = n_to;
        b_ovr   = n_ovr;
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_strobe = 1'b0;
        pkt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(pkt_valid), 64'd0);
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_cmd",   64'(pkt_cmd), 64'd0);
        check("reset_data",  pkt_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Good frame with consumer ready
        snap();
        send(8'hA5);
        check("sof_busy", 64'(busy), 64'd1);
        send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
        check("good_valid", 64'(pkt_valid), 64'd1);
        check("good_cmd",   64'(pkt_cmd), 64'h10);
        check("good_len",   64'(pkt_len), 64'd2);
        check("good_data",  pkt_data, 64'h0000_0000_0000_2211);
        idle(1);
        check("good_valid_drop", 64'(pkt_valid), 64'd0);
        check("good_busy_drop",  64'(busy), 64'd0);
        idle(1);
        check("good_valid_cycles", 64'(n_valid - b_valid), 64'd1);
        check("good_no_err", 64'((n_chk - b_chk) + (n_len - b_len) + (n_to - b_to)), 64'd0);

        // Leading garbage then zero-length frame
        snap();
        send(8'h00); send(8'hFF);
        idle(1);
        check("garbage_busy", 64'(busy), 64'd0);
        send(8'hA5); send(8'h55); send(8'h00); send(8'h55);
        check("zero_valid", 64'(pkt_valid), 64'd1);
        check("zero_cmd",   64'(pkt_cmd), 64'h55);
        check("zero_len",   64'(pkt_len), 64'd0);
        check("zero_data",  pkt_data, 64'd0);
        idle(2);
        check("zero_no_err", 64'((n_chk - b_chk) + (n_len - b_len) + (n_to - b_to)), 64'd0);

        // Bad checksum, then a good frame is accepted
        snap();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h20);
        check("badchk_pulse", 64'(err_chk), 64'd1);
        check("badchk_valid", 64'(pkt_valid), 64'd0);
        check("badchk_busy",  64'(busy), 64'd0);
        idle(1);
        check("badchk_pulse_end", 64'(err_chk), 64'd0);
        send(8'hA5); send(8'h20); send(8'h01); send(8'h7E); send(8'h5F);
        check("after_bad_valid", 64'(pkt_valid), 64'd1);
        check("after_bad_data",  pkt_data, 64'h0000_0000_0000_007E);
        idle(2);
        check("badchk_count", 64'(n_chk - b_chk), 64'd1);

        // Length overflow
        snap();
        send(8'hA5); send(8'h10); send(8'h09);
        check("len_pulse", 64'(err_len), 64'd1);
        check("len_busy",  64'(busy), 64'd0);
        idle(1);
        check("len_pulse_end", 64'(err_len), 64'd0);
        check("len_no_valid", 64'(n_valid - b_valid), 64'd0);

        // 15-cycle stalls survive; a 16-cycle stall times out
        snap();
        send(8'hA5); send(8'h10);
        idle(15);
        send(8'h00);
        idle(15);
        send(8'h10);
        check("stall15_valid", 64'(pkt_valid), 64'd1);
        check("stall15_no_to", 64'(n_to - b_to), 64'd0);
        idle(2);
        send(8'hA5); send(8'h10);
        idle(TMO - 1);
        check("to_early", 64'(err_timeout), 64'd0);
        check("to_early_busy", 64'(busy), 64'd1);
        idle(1);
        check("to_pulse", 64'(err_timeout), 64'd1);
        check("to_busy",  64'(busy), 64'd0);
        idle(1);
        check("to_pulse_end", 64'(err_timeout), 64'd0);

        // Backpressure with bytes dropped while held
        pkt_ready = 1'b0;
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
        snap();
        idle(2);
        send(8'hA5);
        idle(5);
        send(8'h33); send(8'h44);
        idle(40);
        check("bp_overruns", 64'(n_ovr - b_ovr), 64'd3);
        check("bp_valid",    64'(pkt_valid), 64'd1);
        check("bp_cmd",      64'(pkt_cmd), 64'h10);
        check("bp_len",      64'(pkt_len), 64'd2);
        check("bp_data",     pkt_data, 64'h0000_0000_0000_2211);
        pkt_ready = 1'b1;
        idle(1);
        check("bp_release", 64'(pkt_valid), 64'd0);

        // Asynchronous reset in the middle of the payload
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11);
        check("mid_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rx_strobe = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd",  64'(pkt_cmd), 64'd0);
        check("rst_len",  64'(pkt_len), 64'd0);
        check("rst_data", pkt_data, 64'd0);
        check("rst_flags", 64'({pkt_valid, err_chk, err_len, err_timeout, overrun}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send(8'hA5); send(8'h55); send(8'h00); send(8'h55);
        check("post_rst_valid", 64'(pkt_valid), 64'd1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
